// File: rtl/m28_reader.sv
// m28_reader: copies a 2048x8 parallel EEPROM into a 1024x16 RAM.
// Bytes are read in ascending address order. Each pair of bytes is assembled
// into one word, and that word is written to RAM in a single WRITE cycle.
module m28_reader #(
    parameter int ACC_WAIT  = 3,
    parameter int LOW_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [10:0] eep_addr,
    output logic        eep_ce_n,
    output logic        eep_oe_n,
    output logic        eep_we_n,
    input  logic [7:0]  eep_data,
    output logic        we,
    output logic [9:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // Last value of the wait counter, i.e. the cycle whose closing edge samples eep_data.
    localparam logic [3:0] WAIT_LAST = 4'(ACC_WAIT - 1);
    // Pointer parity that selects the upper byte of the word buffer.
    localparam logic       HI_PARITY = (LOW_FIRST != 0);

    state_t      state_reg;
    logic [10:0] ptr_reg;
    logic [3:0]  wait_cnt_reg;
    logic [15:0] word_reg;
    logic [10:0] ptr_next;
    logic [15:0] capture_word;

    // The device is only ever read, so the write strobe stays inactive.
    assign eep_we_n = 1'b1;

    assign ptr_next = ptr_reg + 11'd1;

    // Word buffer with the current eep_data merged into the half that this byte owns.
    always_comb begin
        capture_word = word_reg;
        if (ptr_reg[0] == HI_PARITY) begin
            capture_word[15:8] = eep_data;
        end else begin
            capture_word[7:0] = eep_data;
        end
    end

    // Copy sequencer: state, pointer, and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= 11'd0;
            wait_cnt_reg <= 4'd0;
            word_reg     <= 16'd0;
            eep_addr     <= 11'd0;
            eep_ce_n     <= 1'b1;
            eep_oe_n     <= 1'b1;
            we           <= 1'b0;
            mem_addr     <= 10'd0;
            mem_din      <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_reg <= SETUP;
                        ptr_reg   <= 11'd0;
                        eep_addr  <= 11'd0;
                        eep_ce_n  <= 1'b0;
                        eep_oe_n  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        eep_ce_n  <= 1'b1;
                        eep_oe_n  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= 4'd0;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        eep_ce_n  <= 1'b1;
                        eep_oe_n  <= 1'b1;
                        busy      <= 1'b0;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        word_reg <= capture_word;
                        if (!ptr_reg[0]) begin
                            // First byte of the pair: fetch its partner next.
                            ptr_reg   <= ptr_next;
                            eep_addr  <= ptr_next;
                            state_reg <= SETUP;
                        end else begin
                            // Second byte completes the word: release the EEPROM and write.
                            state_reg <= WRITE;
                            we        <= 1'b1;
                            mem_addr  <= ptr_reg[10:1];
                            mem_din   <= capture_word;
                            eep_ce_n  <= 1'b1;
                            eep_oe_n  <= 1'b1;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end else if (ptr_reg == 11'd2047) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        ptr_reg   <= ptr_next;
                        eep_addr  <= ptr_next;
                        eep_ce_n  <= 1'b0;
                        eep_oe_n  <= 1'b0;
                        state_reg <= SETUP;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    eep_ce_n  <= 1'b1;
                    eep_oe_n  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m28_reader.sv
// Bench for m28_reader: two instances (LOW_FIRST = 1 and 0) share the stimulus.
// Each instance sees an EEPROM whose byte is addr[7:0]^8'h5A.
module tb_m28_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic [10:0] eep_addr_a, eep_addr_b;
    logic        ce_a, oe_a, wen_a, ce_b, oe_b, wen_b;
    logic [7:0]  eep_data_a, eep_data_b;
    logic        we_a, we_b, busy_a, busy_b, done_a, done_b;
    logic [9:0]  mem_addr_a, mem_addr_b;
    logic [15:0] mem_din_a, mem_din_b;

    logic [15:0] ram_a [1024];
    logic [15:0] ram_b [1024];

    int checks = 0;
    int errors = 0;
    int wr_cnt_a = 0;
    int wr_cnt_b = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    always #5 clk = ~clk;

    assign eep_data_a = eep_addr_a[7:0] ^ 8'h5A;
    assign eep_data_b = eep_addr_b[7:0] ^ 8'h5A;

    m28_reader #(.ACC_WAIT(3), .LOW_FIRST(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .eep_addr(eep_addr_a), .eep_ce_n(ce_a), .eep_oe_n(oe_a), .eep_we_n(wen_a),
        .eep_data(eep_data_a), .we(we_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a),
        .busy(busy_a), .done(done_a)
    );

    m28_reader #(.ACC_WAIT(3), .LOW_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .eep_addr(eep_addr_b), .eep_ce_n(ce_b), .eep_oe_n(oe_b), .eep_we_n(wen_b),
        .eep_data(eep_data_b), .we(we_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b),
        .busy(busy_b), .done(done_b)
    );

    // RAM models behind each write port
    always @(posedge clk) begin
        if (we_a) ram_a[mem_addr_a] <= mem_din_a;
        if (we_b) ram_b[mem_addr_b] <= mem_din_b;
    end

    // Expected RAM word w: the two EEPROM bytes 2w and 2w+1, ordered by LOW_FIRST
    function automatic logic [15:0] model_word(input int w, input bit low_first);
        logic [7:0] ev, od;
        ev = 8'((2 * w) & 255) ^ 8'h5A;
        od = 8'((2 * w + 1) & 255) ^ 8'h5A;
        return low_first ? {od, ev} : {ev, od};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_eep_addr"}, 32'(eep_addr_a), 0);
        chk({tag, "_ce_n"}, 32'(ce_a), 1);
        chk({tag, "_oe_n"}, 32'(oe_a), 1);
        chk({tag, "_we_n"}, 32'(wen_a), 1);
        chk({tag, "_we"}, 32'(we_a), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr_a), 0);
        chk({tag, "_mem_din"}, 32'(mem_din_a), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_done"}, 32'(done_a), 0);
        chk({tag, "_b_mem_din"}, 32'(mem_din_b), 0);
    endtask

    // Per-cycle compare: every RAM write must be the next word in order with model data
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && start && !abort && !busy_a && !done_a) begin
                wr_cnt_a = 0;
                wr_cnt_b = 0;
                done_cnt = 0;
                busy_cnt = 0;
            end
            chk("we_n_const", 32'(wen_a), 1);
            chk("oe_follows_ce", 32'(oe_a), 32'(ce_a));
            if (!busy_a) chk("idle_strobes", 32'({ce_a, we_a}), 32'(2'b10));
            if (done_a) chk("done_not_busy", 32'(busy_a), 0);
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            if (we_a) begin
                chk("wr_a_addr", 32'(mem_addr_a), 32'(wr_cnt_a));
                chk("wr_a_data", 32'(mem_din_a), 32'(model_word(wr_cnt_a, 1'b1)));
                chk("wr_a_ce_off", 32'(ce_a), 1);
                wr_cnt_a++;
            end
            if (we_b) begin
                chk("wr_b_addr", 32'(mem_addr_b), 32'(wr_cnt_b));
                chk("wr_b_data", 32'(mem_din_b), 32'(model_word(wr_cnt_b, 1'b0)));
                wr_cnt_b++;
            end
        end
    end

    // Presents start, optionally re-pulses it at byte inj, returns cycles until done
    task automatic run_copy(input int inj, output int lat);
        bit injected;
        injected = 0;
        lat = 0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 1; i <= 20000; i++) begin
            tick();
            start = 1'b0;
            if (inj >= 0 && !injected && busy_a && !ce_a && eep_addr_a == 11'(inj)) begin
                start = 1'b1;
                injected = 1;
            end
            if (done_a) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_byte(input int addr, output bit ok);
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            start = 1'b0;
            if (busy_a && !ce_a && eep_addr_a == 11'(addr)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic check_ram_all(input string tag);
        int bad_a, bad_b;
        bad_a = 0;
        bad_b = 0;
        for (int w = 0; w < 1024; w++) begin
            if (ram_a[w] !== model_word(w, 1'b1)) bad_a++;
            if (ram_b[w] !== model_word(w, 1'b0)) bad_b++;
        end
        chk({tag, "_ram_a_bad_words"}, 32'(bad_a), 0);
        chk({tag, "_ram_b_bad_words"}, 32'(bad_b), 0);
    endtask

    initial begin
        int lat;
        bit ok;

        // Reset held 3 cycles with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy_a), 0);

        // Full copy
        for (int w = 0; w < 1024; w++) begin
            ram_a[w] = 16'h0;
            ram_b[w] = 16'h0;
        end
        run_copy(-1, lat);
        chk("full_done_latency", 32'(lat), 9217);
        chk("full_busy_cycles", 32'(busy_cnt), 9216);
        tick();
        chk("full_done_count", 32'(done_cnt), 1);
        chk("full_done_pulse_off", 32'(done_a), 0);
        chk("full_writes_a", 32'(wr_cnt_a), 1024);
        chk("full_writes_b", 32'(wr_cnt_b), 1024);
        chk("ram_a_0", 32'(ram_a[0]), 32'h5B5A);
        chk("ram_a_1023", 32'(ram_a[1023]), 32'hA5A4);
        chk("ram_b_0", 32'(ram_b[0]), 32'h5A5B);
        chk("ram_b_1023", 32'(ram_b[1023]), 32'hA4A5);
        check_ram_all("full");
        chk("hold_mem_addr", 32'(mem_addr_a), 1023);
        chk("hold_mem_din", 32'(mem_din_a), 32'hA5A4);

        // Abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle_busy", 32'(busy_a), 0);

        // Abort during the write that follows the 10th byte capture
        @(posedge clk);
        #1 start = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            start = 1'b0;
            if (we_a && mem_addr_a == 10'd4) begin
                ok = 1;
                break;
            end
        end
        chk("abort_reached_word4", 32'(ok), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy_next", 32'(busy_a), 0);
        chk("abort_we_next", 32'(we_a), 0);
        repeat (20) tick();
        chk("abort_writes", 32'(wr_cnt_a), 5);
        chk("abort_no_done", 32'(done_cnt), 0);

        // Second start at byte 100 must be ignored
        run_copy(100, lat);
        chk("restart_done_latency", 32'(lat), 9217);
        tick();
        chk("restart_writes", 32'(wr_cnt_a), 1024);
        chk("restart_done_count", 32'(done_cnt), 1);
        tick();
        chk("restart_idle_after", 32'(busy_a), 0);

        // Reset during WAIT of byte 501, then a clean copy
        @(posedge clk);
        #1 start = 1'b1;
        wait_byte(501, ok);
        chk("reached_byte_501", 32'(ok), 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("midreset");
        chk("midreset_writes", 32'(wr_cnt_a), 250);
        repeat (10) tick();
        chk("midreset_writes_after", 32'(wr_cnt_a), 250);
        chk("midreset_no_done", 32'(done_cnt), 0);
        for (int w = 0; w < 1024; w++) begin
            ram_a[w] = 16'h0;
            ram_b[w] = 16'h0;
        end
        run_copy(-1, lat);
        chk("recopy_done_latency", 32'(lat), 9217);
        tick();
        chk("recopy_writes", 32'(wr_cnt_a), 1024);
        chk("recopy_ram_a_0", 32'(ram_a[0]), 32'h5B5A);
        check_ram_all("recopy");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m28_reader.md
M28_READER -- requirements
Module: m28_reader

Parameters
REQ-001 SHALL provide ACC_WAIT, default 3: wait cycles per byte between address setup and data sample; legal range 1..15.
REQ-002 SHALL provide LOW_FIRST, default 1: 1 = even EEPROM byte goes to mem_din[7:0]; 0 = even byte goes to mem_din[15:8].

Interface
REQ-003 SHALL have clk  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have start  in  1  one-cycle request to copy the whole EEPROM into RAM.
REQ-006 SHALL have abort  in  1  terminates a copy in progress.
REQ-007 SHALL have eep_addr  out  11  EEPROM byte address (2048 bytes).
REQ-008 SHALL have eep_ce_n, eep_oe_n, eep_we_n  out  1 each  EEPROM strobes, active-low.
REQ-009 SHALL have eep_data  in  8  EEPROM read data.
REQ-010 SHALL have we  out  1  RAM write strobe, matching the 1024x16 RAM write port.
REQ-011 SHALL have mem_addr  out  10  RAM word address.
REQ-012 SHALL have mem_din  out  16  RAM write data.
REQ-013 SHALL have busy  out  1  high from the accepted start until the copy ends.
REQ-014 SHALL have done  out  1  one-cycle pulse on successful completion.

Function
REQ-015 SHALL implement states IDLE, SETUP, WAIT, WRITE, DONE.
REQ-016 IDLE: start=1 and abort=0 -> SETUP, with the byte pointer cleared to 0; otherwise stay in IDLE.
REQ-017 SETUP: lasts 1 cycle; eep_addr = byte pointer; eep_ce_n = eep_oe_n = 0; goes to WAIT.
REQ-018 WAIT: lasts ACC_WAIT cycles; eep_ce_n = eep_oe_n = 0; eep_addr stays stable.
REQ-019 At the edge that ends the last WAIT cycle, eep_data SHALL be captured into the half of the word buffer selected by pointer bit 0 and LOW_FIRST.
REQ-020 After that capture: an even pointer increments and goes to SETUP; an odd pointer goes to WRITE.
REQ-021 WRITE: lasts 1 cycle; we = 1, mem_addr = pointer[10:1], mem_din = the assembled word; eep_ce_n = eep_oe_n = 1.
REQ-022 WRITE exit: pointer = 2047 -> DONE; otherwise the pointer increments and goes to SETUP.
REQ-023 DONE: lasts 1 cycle; done = 1, busy = 0; returns to IDLE.
REQ-024 busy SHALL be 1 in SETUP, WAIT and WRITE only.
REQ-025 we SHALL be 1 only in WRITE; exactly 1024 writes per full copy, at addresses 0..1023 in ascending order.
REQ-026 A full copy SHALL take 2048*(1+ACC_WAIT)+1024 busy cycles; done follows in the next cycle.
REQ-027 eep_we_n SHALL be constant 1 (read-only device).
REQ-028 eep_ce_n and eep_oe_n SHALL be 1 in IDLE, WRITE and DONE.
REQ-029 start while busy SHALL be ignored, with no restart and no pointer change.
REQ-030 abort=1 in SETUP, WAIT or WRITE SHALL go to IDLE at the next edge, with no done pulse.
REQ-031 After an abort, we is 0 from that edge on and a partially assembled word is never written.
REQ-032 abort and start together in IDLE: abort wins and start is ignored.
REQ-033 Pointer arithmetic SHALL be 11-bit unsigned; no wrap past 2047 is reachable.
REQ-034 mem_addr and mem_din SHALL hold their last values outside WRITE.

Reset
REQ-035 rst_n = 0 at a rising edge SHALL force, at that edge: IDLE, pointer = 0, word buffer = 0.
REQ-036 The same reset edge SHALL force the outputs: eep_addr = 0, eep_ce_n = eep_oe_n = eep_we_n = 1, we = 0, mem_addr = 0, mem_din = 0, busy = 0, done = 0.
REQ-037 Reset mid-copy SHALL behave like abort, with no further RAM writes; a later start SHALL restart from byte 0.

Verification
REQ-038 Reset values: hold rst_n = 0 for 3 cycles -> all outputs at their REQ-036 values; start while rst_n = 0 -> busy stays 0.
REQ-039 Full copy: ACC_WAIT = 3, LOW_FIRST = 1, EEPROM model byte = addr[7:0]^8'h5A.
  -> RAM[0] = 16'h5B5A and RAM[1023] = 16'hA5A4.
  -> exactly 1024 we pulses.
  -> done exactly 9217 cycles after the start edge.
REQ-040 LOW_FIRST = 0, same model -> RAM[0] = 16'h5A5B.
REQ-041 abort after the 10th byte capture -> exactly 5 writes (addresses 0..4), busy = 0 the next cycle, done never asserted.
REQ-042 start pulsed again at byte 100 -> ignored; the copy completes with 1024 writes and a single done.
REQ-043 rst_n = 0 during WAIT of byte 501 -> outputs at reset values next cycle; a new start rewrites RAM from address 0 with correct data.
